// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared constants and FSM encoding for the FP32 add/sub scheduler
package fp_pkg;

  localparam int W_FP = 32;
  localparam int NREQ = 2;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_UNPACK  = 3'd1,
    S_ALIGN   = 3'd2,
    S_ADD     = 3'd3,
    S_NORM    = 3'd4,
    S_CAPTURE = 3'd5,
    S_RESP    = 3'd6
  } state_t;

  localparam logic [3:0] STAGE_NONE   = 4'b0000;
  localparam logic [3:0] STAGE_UNPACK = 4'b0001;
  localparam logic [3:0] STAGE_ALIGN  = 4'b0010;
  localparam logic [3:0] STAGE_ADD    = 4'b0100;
  localparam logic [3:0] STAGE_NORM   = 4'b1000;

  localparam logic [W_FP-1:0] FP_ZERO = 32'h0000_0000;
  localparam logic [W_FP-1:0] QNAN    = 32'h7FC0_0000;

endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-way round-robin grant; ptr picks the winner only on contention
module rr_arbiter2 (
  input  logic [1:0] req_i,
  input  logic       ptr_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = 2'b00;
    if (req_i == 2'b11) begin
      gnt_o = ptr_i ? 2'b10 : 2'b01;
    end else begin
      gnt_o = req_i;
    end
  end

endmodule

// File: rtl/fp_addsub_scheduler.sv
// rtl/fp_addsub_scheduler.sv - shares one staged FP32 add/sub datapath between two requesters
module fp_addsub_scheduler
  import fp_pkg::*;
#(
  parameter int W = W_FP
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [2*W-1:0]    req_a,
  input  logic [2*W-1:0]    req_b,
  input  logic [NREQ-1:0]   req_op,
  output logic [NREQ-1:0]   rsp_valid,
  input  logic [NREQ-1:0]   rsp_ready,
  output logic [W-1:0]      rsp_data,
  output logic [W-1:0]      dp_a,
  output logic [W-1:0]      dp_b,
  output logic              dp_op,
  output logic [3:0]        dp_stage_en,
  input  logic              dp_special,
  input  logic [W-1:0]      dp_result
);

  state_t         state_q, state_d;
  logic           gnt_q, gnt_d;
  logic           rr_q, rr_d;
  logic           op_q, op_d;
  logic [W-1:0]   a_q, a_d, b_q, b_d, data_q, data_d;
  logic [1:0]     arb_gnt;
  logic           accept;
  logic           gnt_idx;

  rr_arbiter2 u_arb (
    .req_i (req_valid),
    .ptr_i (rr_q),
    .gnt_o (arb_gnt)
  );

  // Grant is a subset of valid, so any ready bit is a completed handshake.
  assign req_ready = (state_q == S_IDLE && !reset) ? arb_gnt : 2'b00;
  assign accept    = |req_ready;
  assign gnt_idx   = arb_gnt[1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      gnt_q   <= 1'b0;
      rr_q    <= 1'b0;
      op_q    <= 1'b0;
      a_q     <= FP_ZERO;
      b_q     <= FP_ZERO;
      data_q  <= FP_ZERO;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      rr_q    <= rr_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:    if (accept) state_d = S_UNPACK;
      S_UNPACK:  state_d = dp_special ? S_CAPTURE : S_ALIGN;
      S_ALIGN:   state_d = S_ADD;
      S_ADD:     state_d = S_NORM;
      S_NORM:    state_d = S_CAPTURE;
      S_CAPTURE: state_d = S_RESP;
      S_RESP:    if (rsp_ready[gnt_q]) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    op_d   = op_q;
    gnt_d  = gnt_q;
    rr_d   = rr_q;
    data_d = data_q;
    if (accept) begin
      a_d   = gnt_idx ? req_a[2*W-1:W] : req_a[W-1:0];
      b_d   = gnt_idx ? req_b[2*W-1:W] : req_b[W-1:0];
      op_d  = req_op[gnt_idx];
      gnt_d = gnt_idx;
      rr_d  = ~gnt_idx;
    end
    if (state_q == S_CAPTURE) data_d = dp_result;
  end

  always_comb begin
    dp_stage_en = STAGE_NONE;
    rsp_valid   = 2'b00;
    unique case (state_q)
      S_UNPACK: dp_stage_en = STAGE_UNPACK;
      S_ALIGN:  dp_stage_en = STAGE_ALIGN;
      S_ADD:    dp_stage_en = STAGE_ADD;
      S_NORM:   dp_stage_en = STAGE_NORM;
      S_RESP:   rsp_valid[gnt_q] = 1'b1;
      default:  ;
    endcase
  end

  assign dp_a     = a_q;
  assign dp_b     = b_q;
  assign dp_op    = op_q;
  assign rsp_data = data_q;

endmodule

// File: tb/tb_fp_addsub_scheduler.sv
// tb/tb_fp_addsub_scheduler.sv - self-checking bench for fp_addsub_scheduler
module tb_fp_addsub_scheduler;
  import fp_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  req_valid = 2'b00;
  logic [1:0]  rsp_ready = 2'b00;
  logic [1:0]  req_op = 2'b00;
  logic [63:0] req_a = '0;
  logic [63:0] req_b = '0;
  logic [1:0]  req_ready, rsp_valid;
  logic [31:0] rsp_data, dp_a, dp_b;
  logic        dp_op, dp_special;
  logic [3:0]  dp_stage_en;
  logic [31:0] dp_result = '0;

  int   checks = 0;
  int   failures = 0;
  logic rr_model = 1'b0;

  fp_addsub_scheduler dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_data(rsp_data), .dp_a(dp_a), .dp_b(dp_b),
    .dp_op(dp_op), .dp_stage_en(dp_stage_en), .dp_special(dp_special),
    .dp_result(dp_result)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] int_to_fp(input int v);
    logic        s;
    logic [31:0] mag, sh;
    int          e;
    if (v == 0) return 32'h0;
    s   = (v < 0);
    mag = s ? 32'(-v) : 32'(v);
    e   = 0;
    for (int i = 0; i < 32; i++) if (mag[i]) e = i;
    sh  = mag << (23 - e);
    return {s, 8'(127 + e), sh[22:0]};
  endfunction

  function automatic int fp_to_int(input logic [31:0] x);
    int e, v;
    e = int'(x[30:23]);
    if (e < 127) return 0;
    v = int'({8'b0, 1'b1, x[22:0]} >> (150 - e));
    return x[31] ? -v : v;
  endfunction

  function automatic logic is_special(input logic [31:0] x);
    return (x[30:23] == 8'h00) || (x[30:23] == 8'hFF);
  endfunction

  function automatic logic [31:0] dp_model(input logic [31:0] a, input logic [31:0] b, input logic op);
    if (a[30:23] == 8'hFF || b[30:23] == 8'hFF) return QNAN;
    return int_to_fp(op ? fp_to_int(a) - fp_to_int(b) : fp_to_int(a) + fp_to_int(b));
  endfunction

  // Behavioural datapath: result only appears the cycle after the final stage.
  assign dp_special = dp_stage_en[0] && (is_special(dp_a) || is_special(dp_b));
  always @(posedge clk) begin
    if (dp_stage_en[3] || (dp_stage_en[0] && dp_special)) dp_result <= dp_model(dp_a, dp_b, dp_op);
    else dp_result <= 32'hDEAD_BEEF;
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic post(input int r, input logic [31:0] a, input logic [31:0] b, input logic op);
    req_a[r*32 +: 32] = a;
    req_b[r*32 +: 32] = b;
    req_op[r]         = op;
    req_valid[r]      = 1'b1;
  endtask

  function automatic int exp_grant(input logic [1:0] v);
    if (v == 2'b11) return int'(rr_model);
    return v[1] ? 1 : 0;
  endfunction

  task automatic serve(input int g, input logic [31:0] exp_data, input int exp_lat, input int hold);
    logic [1:0]  gm, om;
    logic [15:0] seq;
    logic        bad_ready, unstable;
    int          cyc, lat;
    gm = 2'(1 << g);
    om = 2'(1 << (1 - g));
    #1;
    cyc = 0;
    while (req_ready == 2'b00 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("grant", req_ready, gm);
    rr_model = (g == 0);
    @(posedge clk);
    @(negedge clk);
    req_valid[g] = 1'b0;
    lat = 1; seq = '0; bad_ready = 1'b0;
    while (rsp_valid == 2'b00 && lat < 20) begin
      if (dp_stage_en != 4'b0) seq = {seq[11:0], dp_stage_en};
      if (req_ready != 2'b00) bad_ready = 1'b1;
      @(negedge clk);
      lat++;
    end
    check("latency", lat, exp_lat);
    check("rsp_valid", rsp_valid, gm);
    check("rsp_data", rsp_data, exp_data);
    check("stage_seq", seq, (exp_lat == 6) ? 16'h1248 : 16'h0001);
    check("busy_ready", bad_ready, 1'b0);
    if (hold > 0) begin
      unstable = 1'b0;
      req_valid[1-g] = 1'b1;
      rsp_ready = om;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        if (rsp_valid !== gm || rsp_data !== exp_data || req_ready !== 2'b00) unstable = 1'b1;
      end
      rsp_ready = 2'b00;
      check("hold_stable", unstable, 1'b0);
    end
    rsp_ready[g] = 1'b1;
    @(negedge clk);
    rsp_ready = 2'b00;
    check("idle_after_rsp", rsp_valid, 2'b00);
    if (hold > 0) begin
      check("idle_ready", req_ready, om);
      req_valid[1-g] = 1'b0;
    end
  endtask

  typedef struct {
    int          r;
    logic [31:0] a, b;
    logic        op;
    logic [31:0] exp_data;
    int          exp_lat;
    int          hold;
  } vec_t;

  vec_t vecs[4];

  initial begin
    logic bad;
    vecs[0] = '{0, 32'h40400000, 32'h40000000, 1'b0, 32'h40A00000, 6, 0};
    vecs[1] = '{1, 32'h40000000, 32'h40400000, 1'b1, 32'hBF800000, 6, 0};
    vecs[2] = '{0, 32'h7FC00000, 32'h3F800000, 1'b0, 32'h7FC00000, 3, 0};
    vecs[3] = '{1, 32'h40E00000, 32'h40400000, 1'b0, 32'h41200000, 6, 10};

    repeat (3) @(negedge clk);
    check("reset_outputs", {rsp_valid, req_ready, rsp_data, dp_a, dp_b, dp_op, dp_stage_en}, '0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 4; i++) begin
      post(vecs[i].r, vecs[i].a, vecs[i].b, vecs[i].op);
      serve(vecs[i].r, vecs[i].exp_data, vecs[i].exp_lat, vecs[i].hold);
    end

    reset = 1'b1; rr_model = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    post(0, int_to_fp(4), int_to_fp(1), 1'b0);
    post(1, int_to_fp(9), int_to_fp(2), 1'b1);
    serve(0, int_to_fp(5), 6, 0);
    serve(1, int_to_fp(7), 6, 0);
    post(0, int_to_fp(1), int_to_fp(1), 1'b0);
    serve(0, int_to_fp(2), 6, 0);
    post(0, int_to_fp(6), int_to_fp(6), 1'b0);
    post(1, int_to_fp(8), int_to_fp(20), 1'b1);
    serve(1, int_to_fp(-12), 6, 0);
    serve(0, int_to_fp(12), 6, 0);

    post(0, int_to_fp(12), int_to_fp(5), 1'b0);
    #1;
    check("mid_grant", req_ready, 2'b01);
    @(posedge clk);
    @(negedge clk);
    req_valid = 2'b00;
    @(negedge clk);
    @(negedge clk);
    check("stage_add", dp_stage_en, 4'b0100);
    reset = 1'b1; rr_model = 1'b0;
    #1;
    check("reset_mid_outputs", {rsp_valid, req_ready, rsp_data, dp_a, dp_b, dp_op, dp_stage_en}, '0);
    @(negedge clk);
    reset = 1'b0;
    bad = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (rsp_valid != 2'b00) bad = 1'b1;
    end
    check("no_rsp_after_reset", bad, 1'b0);
    post(1, int_to_fp(-3), int_to_fp(11), 1'b0);
    serve(1, int_to_fp(8), 6, 0);

    for (int it = 0; it < 24; it++) begin
      logic [1:0] m;
      int         ia[2], ib[2], g;
      logic       op[2];
      m = 2'($urandom_range(1, 3));
      for (int r = 0; r < 2; r++) begin
        ia[r] = ($urandom_range(0, 6) == 0) ? 0 : int'($urandom_range(0, 2000)) - 1000;
        ib[r] = ($urandom_range(0, 6) == 0) ? 0 : int'($urandom_range(0, 2000)) - 1000;
        op[r] = 1'($urandom_range(0, 1));
        if (m[r]) post(r, int_to_fp(ia[r]), int_to_fp(ib[r]), op[r]);
      end
      g = exp_grant(m);
      serve(g, int_to_fp(op[g] ? ia[g] - ib[g] : ia[g] + ib[g]),
            (ia[g] == 0 || ib[g] == 0) ? 3 : 6, 0);
      if (m == 2'b11) begin
        g = 1 - g;
        serve(g, int_to_fp(op[g] ? ia[g] - ib[g] : ia[g] + ib[g]),
              (ia[g] == 0 || ib[g] == 0) ? 3 : 6, 0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
